spi_byte_arbiter: RTL

- Shares the single SPI byte engine (start/done/data_in/data_out handshake) between NUM_REQ requesters, e.g. the SD init/read sequencer and a config/status poller.
- Grants round-robin. Holds the grant across multi-byte SD commands while the owner asserts lock.
- Owns the card chip-select, so command frames from different requesters never interleave.
- Adds a per-byte watchdog so a stuck engine cannot hang the system.

---
 rtl/spi_byte_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_byte_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between NUM_REQ requesters.
// Owns the card chip-select, holds the grant under lock, and aborts stuck bytes with a watchdog.
module spi_byte_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TW             = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     lock,
  input  logic [NUM_REQ-1:0]     req_start,
  input  logic [8*NUM_REQ-1:0]   req_tx,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [7:0]             rx_data,
  output logic                   spi_start,
  output logic [7:0]             spi_data_in,
  input  logic                   spi_done,
  input  logic [7:0]             spi_data_out,
  output logic                   cs_n
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [TW-1:0]   watchdog;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   owner_idx;
  logic [PW-1:0]   next_ptr;
  logic            owner_req;
  logic            owner_lock;
  logic            owner_start;
  logic [7:0]      owner_tx;

  // First requester at or after rr_ptr, wrapping; the reverse scan leaves the nearest one last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = PW'((int'(rr_ptr) + i) % int'(NUM_REQ));
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Owner's view of the request lines, selected by the one-hot grant.
  always_comb begin
    owner_idx   = '0;
    owner_req   = 1'b0;
    owner_lock  = 1'b0;
    owner_start = 1'b0;
    owner_tx    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        owner_idx   = PW'(i);
        owner_req   = req[i];
        owner_lock  = lock[i];
        owner_start = req_start[i];
        owner_tx    = req_tx[8*i +: 8];
      end
    end
    next_ptr = (owner_idx == PW'(NUM_REQ - 1)) ? '0 : owner_idx + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      req_done    <= '0;
      req_err     <= '0;
      rx_data     <= 8'hFF;
      spi_start   <= 1'b0;
      spi_data_in <= 8'hFF;
      cs_n        <= 1'b1;
      rr_ptr      <= '0;
      watchdog    <= '0;
    end else begin
      spi_start <= 1'b0;
      req_done  <= '0;
      req_err   <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= NUM_REQ'(1) << pick_idx;
            cs_n  <= 1'b0;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          // A start in the same cycle as the owner letting go still wins.
          if (owner_start) begin
            spi_data_in <= owner_tx;
            spi_start   <= 1'b1;
            watchdog    <= '0;
            state       <= BUSY;
          end else if (!owner_req && !owner_lock) begin
            cs_n  <= 1'b1;
            state <= RELEASE;
          end
        end
        BUSY: begin
          if (spi_done) begin
            rx_data  <= spi_data_out;
            req_done <= gnt;
            if (owner_lock) begin
              state <= GRANTED;
            end else begin
              cs_n  <= 1'b1;
              state <= RELEASE;
            end
          end else if (watchdog == TW'(TIMEOUT_CYCLES - 1)) begin
            // Engine is stuck: abort the byte and drop the card regardless of lock.
            req_done <= gnt;
            req_err  <= gnt;
            rx_data  <= 8'hFF;
            cs_n     <= 1'b1;
            state    <= RELEASE;
          end else begin
            watchdog <= watchdog + TW'(1);
          end
        end
        RELEASE: begin
          gnt    <= '0;
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
